// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle cpu_core: opcodes, ALU function codes,
// instruction field positions, FSM states and status codes written to r30.
package cpu_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] FN_ADD = 5'b00000;
    localparam logic [4:0] FN_SUB = 5'b00001;
    localparam logic [4:0] FN_AND = 5'b00010;
    localparam logic [4:0] FN_OR  = 5'b00011;
    localparam logic [4:0] FN_SLL = 5'b00100;
    localparam logic [4:0] FN_SRA = 5'b00101;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;
    localparam int SH_HI  = 11;
    localparam int SH_LO  = 7;
    localparam int FN_HI  = 6;
    localparam int FN_LO  = 2;
    localparam int IMM_HI = 16;
    localparam int T_HI   = 26;

    localparam logic [4:0] REG_RSTATUS = 5'd30;
    localparam logic [4:0] REG_LINK    = 5'd31;

    localparam logic [31:0] RSTATUS_ADD  = 32'd1;
    localparam logic [31:0] RSTATUS_ADDI = 32'd2;
    localparam logic [31:0] RSTATUS_SUB  = 32'd3;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRA = 3'd5
    } alu_op_e;

    function automatic logic [31:0] sext_imm(input logic [16:0] imm);
        return {{15{imm[16]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: add/sub/and/or/sll/sra with signed overflow flag and
// a signed less-than compare of the two operands.
module cpu_alu
    import cpu_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        overflow,
    output logic        less
);

    logic [31:0] sum_s;
    logic [31:0] diff_s;

    assign sum_s  = a + b;
    assign diff_s = a - b;
    assign less   = ($signed(a) < $signed(b));

    // result select and two's-complement overflow detection
    always_comb begin
        result   = 32'd0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sum_s;
                overflow = (a[31] == b[31]) && (sum_s[31] != a[31]);
            end
            ALU_SUB: begin
                result   = diff_s;
                overflow = (a[31] != b[31]) && (diff_s[31] != a[31]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLL: result = a << shamt;
            ALU_SRA: result = $unsigned($signed(a) >>> shamt);
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// Non-pipelined multi-cycle 32-bit core: FETCH -> EXEC (-> MEM for lw).
// Architectural side effects are committed on the edge leaving EXEC, or MEM for lw.
module cpu_core
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    output logic        wren,
    output logic [31:0] address_dmem,
    output logic [31:0] data,
    input  logic [31:0] q_dmem
);

    state_e      state_r;
    state_e      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pc_inc_s;
    logic [31:0] branch_pc_s;

    logic [4:0]  op_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  shamt_s;
    logic [4:0]  fn_s;
    logic [31:0] imm_s;
    logic [31:0] target_s;

    alu_op_e     alu_op_s;
    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [31:0] alu_result_s;
    logic        alu_ovf_s;
    logic        alu_less_s;

    logic [4:0]  read_a_s;
    logic [4:0]  read_b_s;

    logic        ex_we_s;
    logic [4:0]  ex_wreg_s;
    logic [31:0] ex_wdata_s;
    logic        ex_wren_s;
    logic [31:0] ex_npc_s;

    logic        we_s;
    logic [4:0]  wreg_s;
    logic [31:0] wdata_s;
    logic        wren_s;
    logic [31:0] daddr_s;

    assign op_s        = q_imem[OP_HI:OP_LO];
    assign rd_s        = q_imem[RD_HI:RD_LO];
    assign rs_s        = q_imem[RS_HI:RS_LO];
    assign rt_s        = q_imem[RT_HI:RT_LO];
    assign shamt_s     = q_imem[SH_HI:SH_LO];
    assign fn_s        = q_imem[FN_HI:FN_LO];
    assign imm_s       = sext_imm(q_imem[IMM_HI:0]);
    assign target_s    = {5'd0, q_imem[T_HI:0]};
    assign pc_inc_s    = pc_r + 32'd1;
    assign branch_pc_s = pc_inc_s + imm_s;

    cpu_alu u_alu (
        .op       (alu_op_s),
        .a        (alu_a_s),
        .b        (alu_b_s),
        .shamt    (shamt_s),
        .result   (alu_result_s),
        .overflow (alu_ovf_s),
        .less     (alu_less_s)
    );

    // state and PC register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
        end
    end

    // register-file read indices and ALU operand selection
    always_comb begin
        read_a_s = rs_s;
        read_b_s = rd_s;
        alu_op_s = ALU_ADD;
        alu_a_s  = data_readRegA;
        alu_b_s  = imm_s;
        case (op_s)
            OP_RTYPE: begin
                read_b_s = rt_s;
                alu_b_s  = data_readRegB;
                case (fn_s)
                    FN_SUB:  alu_op_s = ALU_SUB;
                    FN_AND:  alu_op_s = ALU_AND;
                    FN_OR:   alu_op_s = ALU_OR;
                    FN_SLL:  alu_op_s = ALU_SLL;
                    FN_SRA:  alu_op_s = ALU_SRA;
                    default: alu_op_s = ALU_ADD;
                endcase
            end
            OP_JR:   read_a_s = rd_s;
            // blt compares rd < rs, so swap operands into the ALU comparator
            OP_BLT: begin
                alu_a_s = data_readRegB;
                alu_b_s = data_readRegA;
            end
            OP_BEX:  read_a_s = REG_RSTATUS;
            default: read_a_s = rs_s;
        endcase
    end

    // per-instruction effects committed at the end of EXEC
    always_comb begin
        ex_we_s    = 1'b0;
        ex_wreg_s  = rd_s;
        ex_wdata_s = alu_result_s;
        ex_wren_s  = 1'b0;
        ex_npc_s   = pc_inc_s;
        case (op_s)
            OP_RTYPE: begin
                case (fn_s)
                    FN_ADD, FN_SUB: begin
                        ex_we_s = 1'b1;
                        if (alu_ovf_s) begin
                            ex_wreg_s  = REG_RSTATUS;
                            ex_wdata_s = (fn_s == FN_ADD) ? RSTATUS_ADD : RSTATUS_SUB;
                        end else begin
                            ex_wreg_s  = rd_s;
                            ex_wdata_s = alu_result_s;
                        end
                    end
                    FN_AND, FN_OR, FN_SLL, FN_SRA: ex_we_s = 1'b1;
                    default: ex_we_s = 1'b0;
                endcase
            end
            OP_ADDI: begin
                ex_we_s = 1'b1;
                if (alu_ovf_s) begin
                    ex_wreg_s  = REG_RSTATUS;
                    ex_wdata_s = RSTATUS_ADDI;
                end else begin
                    ex_wreg_s  = rd_s;
                    ex_wdata_s = alu_result_s;
                end
            end
            OP_SW:   ex_wren_s = 1'b1;
            OP_J:    ex_npc_s  = target_s;
            OP_JAL: begin
                ex_we_s    = 1'b1;
                ex_wreg_s  = REG_LINK;
                ex_wdata_s = pc_inc_s;
                ex_npc_s   = target_s;
            end
            OP_JR:   ex_npc_s = data_readRegA;
            OP_BNE: begin
                if (data_readRegA != data_readRegB) begin
                    ex_npc_s = branch_pc_s;
                end else begin
                    ex_npc_s = pc_inc_s;
                end
            end
            OP_BLT: begin
                if (alu_less_s) begin
                    ex_npc_s = branch_pc_s;
                end else begin
                    ex_npc_s = pc_inc_s;
                end
            end
            OP_BEX: begin
                if (data_readRegA != 32'd0) begin
                    ex_npc_s = target_s;
                end else begin
                    ex_npc_s = pc_inc_s;
                end
            end
            OP_SETX: begin
                ex_we_s    = 1'b1;
                ex_wreg_s  = REG_RSTATUS;
                ex_wdata_s = target_s;
            end
            default: ex_we_s = 1'b0;
        endcase
    end

    // FSM next state and state-qualified strobes
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        we_s         = 1'b0;
        wreg_s       = rd_s;
        wdata_s      = ex_wdata_s;
        wren_s       = 1'b0;
        daddr_s      = 32'd0;
        case (state_r)
            ST_FETCH: state_next_s = ST_EXEC;
            ST_EXEC: begin
                if (op_s == OP_LW) begin
                    state_next_s = ST_MEM;
                    daddr_s      = alu_result_s;
                end else begin
                    state_next_s = ST_FETCH;
                    pc_next_s    = ex_npc_s;
                    we_s         = ex_we_s;
                    wreg_s       = ex_wreg_s;
                    wdata_s      = ex_wdata_s;
                    wren_s       = ex_wren_s;
                    daddr_s      = (op_s == OP_SW) ? alu_result_s : 32'd0;
                end
            end
            // instruction word and read indices are still stable here, so the address holds
            ST_MEM: begin
                state_next_s = ST_FETCH;
                pc_next_s    = pc_inc_s;
                we_s         = 1'b1;
                wreg_s       = rd_s;
                wdata_s      = q_dmem;
                daddr_s      = alu_result_s;
            end
            default: begin
                state_next_s = ST_FETCH;
                pc_next_s    = RESET_PC;
            end
        endcase
    end

    assign address_imem     = pc_r;
    assign ctrl_readRegA    = read_a_s;
    assign ctrl_readRegB    = read_b_s;
    assign ctrl_writeEnable = we_s & reset;
    assign ctrl_writeReg    = wreg_s;
    assign data_writeReg    = wdata_s;
    assign wren             = wren_s & reset;
    assign address_dmem     = daddr_s;
    assign data             = data_readRegB;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: models ROM/regfile/RAM and compares the core
// against an instruction-level interpreter over directed and random programs.
module tb_cpu_core;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_imem;
    logic [31:0] q_imem;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;

    always #5 clock = ~clock;

    cpu_core #(.RESET_PC(32'd0)) dut (
        .clock            (clock),
        .reset            (reset),
        .address_imem     (address_imem),
        .q_imem           (q_imem),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .wren             (wren),
        .address_dmem     (address_dmem),
        .data             (data),
        .q_dmem           (q_dmem)
    );

    logic [31:0] rom     [0:255];
    logic [31:0] rf      [0:31];
    logic [31:0] rf_init [0:31];
    logic [31:0] ram     [0:4095];

    always @(posedge clock) q_imem <= rom[address_imem[7:0]];

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_init[i];
            for (int i = 0; i < 4096; i++) ram[i] <= 32'd0;
        end else begin
            if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
            if (wren) ram[address_dmem[11:0]] <= data;
        end
        q_dmem <= ram[address_dmem[11:0]];
    end

    assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : rf[ctrl_readRegA];
    assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : rf[ctrl_readRegB];

    int          cyc = 0;
    int          wr_cyc [$];
    logic [4:0]  wr_reg [$];
    logic [31:0] wr_dat [$];
    int          mw_cyc [$];
    logic [31:0] mw_addr [$];
    logic [31:0] mw_dat [$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (ctrl_writeEnable === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_reg.push_back(ctrl_writeReg);
            wr_dat.push_back(data_writeReg);
        end
        if (wren === 1'b1) begin
            mw_cyc.push_back(cyc);
            mw_addr.push_back(address_dmem);
            mw_dat.push_back(data);
        end
    end

    int tests = 0;
    int fails = 0;
    int wbase = 0;
    int mbase = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt,
                                          input int sh, input int fn);
        logic [31:0] a, b, c, d, e;
        a = rd; b = rs; c = rt; d = sh; e = fn;
        return {5'd0, a[4:0], b[4:0], c[4:0], d[4:0], e[4:0], 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rd, input int rs, input int imm);
        logic [31:0] o, a, b, v;
        o = op; a = rd; b = rs; v = imm;
        return {o[4:0], a[4:0], b[4:0], v[16:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int t);
        logic [31:0] o, v;
        o = op; v = t;
        return {o[4:0], v[26:0]};
    endfunction

    // Instruction-level reference model
    logic [31:0] m_rf  [0:31];
    logic [31:0] m_mem [0:4095];
    logic [31:0] m_pc;
    int          m_cycles;

    task automatic model_reset();
        m_pc = 32'd0;
        m_cycles = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = rf_init[i];
        m_rf[0] = 32'd0;
        for (int i = 0; i < 4096; i++) m_mem[i] = 32'd0;
    endtask

    task automatic m_write(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_rf[r] = v;
    endtask

    task automatic model_step();
        logic [31:0] ins, a_rd, a_rs, a_rt, n, t, nxt, addr, res;
        logic [4:0]  op, rd, rs, rt, sh, fn;
        longint      s;
        ins  = rom[m_pc[7:0]];
        op   = ins[31:27]; rd = ins[26:22]; rs = ins[21:17];
        rt   = ins[16:12]; sh = ins[11:7];  fn = ins[6:2];
        n    = {{15{ins[16]}}, ins[16:0]};
        t    = {5'd0, ins[26:0]};
        a_rd = m_rf[rd]; a_rs = m_rf[rs]; a_rt = m_rf[rt];
        addr = a_rs + n;
        nxt  = m_pc + 32'd1;
        m_cycles += 2;
        case (op)
            5'd0: begin
                case (fn)
                    5'd0: begin
                        s = longint'($signed(a_rs)) + longint'($signed(a_rt));
                        if (s > 64'sd2147483647 || s < -64'sd2147483648) m_write(5'd30, 32'd1);
                        else m_write(rd, s[31:0]);
                    end
                    5'd1: begin
                        s = longint'($signed(a_rs)) - longint'($signed(a_rt));
                        if (s > 64'sd2147483647 || s < -64'sd2147483648) m_write(5'd30, 32'd3);
                        else m_write(rd, s[31:0]);
                    end
                    5'd2: m_write(rd, a_rs & a_rt);
                    5'd3: m_write(rd, a_rs | a_rt);
                    5'd4: m_write(rd, a_rs << sh);
                    5'd5: begin
                        res = $signed(a_rs) >>> sh;
                        m_write(rd, res);
                    end
                    default: ;
                endcase
            end
            5'd5: begin
                s = longint'($signed(a_rs)) + longint'($signed(n));
                if (s > 64'sd2147483647 || s < -64'sd2147483648) m_write(5'd30, 32'd2);
                else m_write(rd, s[31:0]);
            end
            5'd7: m_mem[addr[11:0]] = a_rd;
            5'd8: begin
                m_write(rd, m_mem[addr[11:0]]);
                m_cycles += 1;
            end
            5'd1: nxt = t;
            5'd3: begin
                m_write(5'd31, m_pc + 32'd1);
                nxt = t;
            end
            5'd4: nxt = a_rd;
            5'd2: if (a_rd != a_rs) nxt = m_pc + 32'd1 + n;
            5'd6: if ($signed(a_rd) < $signed(a_rs)) nxt = m_pc + 32'd1 + n;
            5'd22: if (m_rf[30] != 32'd0) nxt = t;
            5'd21: m_write(5'd30, t);
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) rom[i] = 32'd0;
        for (int i = 0; i < 32; i++) rf_init[i] = 32'd0;
    endtask

    task automatic run_prog(input string name, input int n);
        int bad;
        model_reset();
        for (int i = 0; i < n; i++) model_step();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        wbase = wr_cyc.size();
        mbase = mw_cyc.size();
        repeat (m_cycles) @(posedge clock);
        @(negedge clock);
        check({name, " pc"}, address_imem, m_pc);
        check({name, " we_in_fetch"}, {31'd0, ctrl_writeEnable}, 32'd0);
        for (int r = 1; r < 32; r++) check($sformatf("%s r%0d", name, r), rf[r[4:0]], m_rf[r[4:0]]);
        bad = -1;
        for (int i = 0; i < 4096; i++) if (bad < 0 && ram[i[11:0]] !== m_mem[i[11:0]]) bad = i;
        tests++;
        assert (bad == -1) else begin
            fails++;
            $error("FAIL %s ram: word %0d observed %h expected %h", name, bad, ram[bad], m_mem[bad]);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2, 3: return enc_r($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                                     $urandom_range(0, 31), $urandom_range(0, 7));
            4: return enc_i(5, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
            5: return enc_i(7, $urandom_range(0, 31), 0, $urandom_range(0, 15));
            6: return enc_i(8, $urandom_range(0, 31), 0, $urandom_range(0, 15));
            7: return enc_j(21, $urandom);
            8: return enc_i(($urandom_range(0, 1) == 0) ? 2 : 6, $urandom_range(0, 31),
                            $urandom_range(0, 31), $urandom_range(0, 3));
            default: return enc_j(31, $urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        clear_prog();

        // reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset pc", address_imem, 32'd0);
        check("reset we", {31'd0, ctrl_writeEnable}, 32'd0);
        check("reset wren", {31'd0, wren}, 32'd0);

        // A: addi/addi/add, writes two cycles apart
        clear_prog();
        rom[0] = enc_i(5, 1, 0, 5);
        rom[1] = enc_i(5, 2, 0, -3);
        rom[2] = enc_r(3, 1, 2, 0, 0);
        run_prog("A", 3);
        check("A r1", rf[1], 32'd5);
        check("A r2", rf[2], 32'hFFFF_FFFD);
        check("A r3", rf[3], 32'd2);
        check("A nwrites", wr_cyc.size() - wbase, 32'd3);
        if (wr_cyc.size() - wbase >= 3) begin
            check("A gap1", wr_cyc[wbase + 1] - wr_cyc[wbase], 32'd2);
            check("A gap2", wr_cyc[wbase + 2] - wr_cyc[wbase + 1], 32'd2);
        end

        // B: overflow on add goes to r30
        clear_prog();
        rom[0] = enc_i(5, 1, 0, 65535);
        rom[1] = enc_r(1, 1, 0, 15, 4);
        rom[2] = enc_r(2, 1, 1, 0, 0);
        run_prog("B", 3);
        check("B r1", rf[1], 32'd2147450880);
        check("B r30", rf[30], 32'd1);
        check("B r2", rf[2], 32'd0);

        // C: sw then lw through RAM
        clear_prog();
        rom[0] = enc_i(5, 4, 0, 77);
        rom[1] = enc_i(7, 4, 0, 3);
        rom[2] = enc_i(8, 5, 0, 3);
        run_prog("C", 3);
        check("C r5", rf[5], 32'd77);
        check("C pc3", address_imem, 32'd3);
        check("C nwren", mw_cyc.size() - mbase, 32'd1);
        check("C nwrites", wr_cyc.size() - wbase, 32'd2);
        if (mw_cyc.size() - mbase >= 1 && wr_cyc.size() - wbase >= 2) begin
            check("C wren addr", mw_addr[mbase], 32'd3);
            check("C wren data", mw_dat[mbase], 32'd77);
            check("C wren time", mw_cyc[mbase] - wr_cyc[wbase], 32'd2);
            check("C lw time", wr_cyc[wbase + 1] - wr_cyc[wbase], 32'd5);
            check("C lw reg", {27'd0, wr_reg[wbase + 1]}, 32'd5);
            check("C lw data", wr_dat[wbase + 1], 32'd77);
        end

        // D: blt taken skips two, bne r1,r1 not taken
        clear_prog();
        rom[0] = enc_i(5, 1, 0, 1);
        rom[1] = enc_i(6, 0, 1, 2);
        rom[2] = enc_i(5, 6, 0, 9);
        rom[3] = enc_i(5, 7, 0, 9);
        rom[4] = enc_i(5, 8, 0, 1);
        run_prog("Dblt", 3);
        check("Dblt r6", rf[6], 32'd0);
        check("Dblt r7", rf[7], 32'd0);
        check("Dblt r8", rf[8], 32'd1);
        rom[1] = enc_i(2, 1, 1, 2);
        run_prog("Dbne", 5);
        check("Dbne r6", rf[6], 32'd9);
        check("Dbne r7", rf[7], 32'd9);
        check("Dbne pc", address_imem, 32'd5);

        // E: jal at 4 then jr r31; zero words are add r0 writes
        clear_prog();
        rom[4]  = enc_j(3, 10);
        rom[10] = enc_i(4, 31, 0, 0);
        run_prog("Ejal", 5);
        check("Ejal pc", address_imem, 32'd10);
        check("Ejal r31", rf[31], 32'd5);
        check("Ejal nwrites", wr_cyc.size() - wbase, 32'd5);
        run_prog("Ejr", 6);
        check("Ejr pc", address_imem, 32'd5);

        // F: setx/bex taken, bex with r30=0 falls through
        clear_prog();
        rom[0] = enc_j(21, 9);
        rom[1] = enc_j(22, 20);
        run_prog("Fbex", 2);
        check("Fbex pc", address_imem, 32'd20);
        check("Fbex r30", rf[30], 32'd9);
        rom[0] = enc_j(22, 20);
        run_prog("Fnobex", 1);
        check("Fnobex pc", address_imem, 32'd1);

        // reset asserted during EXEC abandons the instruction
        clear_prog();
        rom[0] = enc_i(5, 1, 0, 5);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("mid we_exec", {31'd0, ctrl_writeEnable}, 32'd1);
        reset = 1'b0;
        #1;
        wbase = wr_cyc.size();
        check("mid we_gated", {31'd0, ctrl_writeEnable}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("mid pc", address_imem, 32'd0);
        check("mid nwrites", wr_cyc.size() - wbase, 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("mid rerun r1", rf[1], 32'd5);
        check("mid rerun pc", address_imem, 32'd1);

        // random programs against the reference interpreter
        for (int k = 0; k < 6; k++) begin
            clear_prog();
            for (int r = 1; r < 32; r++) rf_init[r] = $urandom;
            for (int i = 0; i < 40; i++) rom[i] = rand_instr();
            run_prog($sformatf("rand%0d", k), 40);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Non-pipelined, multi-cycle 32-bit processor core with a word-addressed PC.
- Fetches from an external synchronous instruction ROM.
- Reads and writes an external two-read/one-write register file.
- Loads and stores through an external synchronous data RAM.
- Sits between the ROM, regfile and RAM in the system wrapper; contains no storage beyond PC, FSM state and the overflow-status path.

Parameters:
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- address_imem  out  32  instruction address; equals PC.
- q_imem  in  32  instruction word; the ROM registers it one edge after the address.
- ctrl_writeEnable  out  1  regfile write strobe.
- ctrl_writeReg  out  5  regfile write index.
- ctrl_readRegA  out  5  regfile read index A.
- ctrl_readRegB  out  5  regfile read index B.
- data_writeReg  out  32  regfile write data.
- data_readRegA  in  32  combinational read data A.
- data_readRegB  in  32  combinational read data B.
- wren  out  1  RAM write enable.
- address_dmem  out  32  RAM address; the RAM uses bits [11:0].
- data  out  32  RAM write data.
- q_dmem  in  32  RAM read data; registered one edge after the address.

Behaviour:
- Reset: reset low at a rising edge gives PC=RESET_PC and state=FETCH. ctrl_writeEnable=0 and wren=0 while in FETCH.
- Formats:
  - R: op[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2].
  - I: op, rd, rs, imm[16:0], sign-extended to 32 bits (N).
  - JI: op, T[26:0], zero-extended.
- FSM states:
  - FETCH: always goes to EXEC.
  - EXEC: goes to MEM for lw, otherwise to FETCH.
  - MEM: always goes to FETCH.
  - CPI is 2; lw takes 3.
- Side effects: every register write, RAM write and PC update happens on the edge that leaves EXEC, or leaves MEM for lw. Default next PC is PC+1.
- Opcodes:
  - 00000 R-type, aluop:
    - 00000 add, 00001 sub, 00010 and, 00011 or.
    - 00100 sll by shamt, 00101 sra by shamt.
    - Other aluop values: nop.
  - 00101 addi: rd=rs+N.
  - 00111 sw: MEM[rs+N]=rd. readRegB=rd; data=data_readRegB; wren=1 in EXEC only.
  - 01000 lw: rd=MEM[rs+N]. address_dmem and read indices held through MEM; write q_dmem in MEM.
  - 00001 j: PC=T.
  - 00011 jal: r31=PC+1, PC=T.
  - 00100 jr: PC=rd; readRegA=rd.
  - 00010 bne: if rd!=rs, PC=PC+1+N. readRegA=rs, readRegB=rd.
  - 00110 blt: if rd<rs (signed), PC=PC+1+N.
  - 10110 bex: if r30!=0, PC=T; readRegA=30.
  - 10101 setx: r30=T.
  - Undefined opcodes: nop.
- Overflow: signed overflow on add, addi or sub writes r30 instead of rd, with value 1, 2 or 3 respectively.
- Register 0: a write to index 0 leaves ctrl_writeEnable asserted. The regfile discards it.
- Width rules:
  - PC arithmetic wraps modulo 2^32.
  - Shifts use shamt[4:0].
  - All ALU results are 32-bit two's complement.
- Reset mid-instruction: the instruction is abandoned with no write. PC and state revert as above.

Decomposition:
- Package cpu_pkg holds:
  - opcode and aluop constants;
  - FSM state enum;
  - field bit-position constants;
  - the rstatus codes 1, 2 and 3.
- One sub-module, cpu_alu: combinational add/sub/and/or/sll/sra with overflow flag and signed less-than.

Test Plan:
- addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 -> r1=5, r2=-3, r3=2. Writes occur 2 cycles apart.
- addi r1,r0,65535; sll r1,r1,15; add r2,r1,r1 -> r1=2147450880. Overflow writes r30=1; r2 is unchanged (0).
- addi r4,r0,77; sw r4,3(r0); lw r5,3(r0) -> wren pulses once at address 3 with data=77. r5=77 written in MEM state; lw takes 3 cycles.
- addi r1,r0,1; blt r0,r1,+2 skips two addi -> skipped registers remain 0. Repeat with bne r1,r1 -> not taken.
- jal 10 at PC=4 -> r31=5, next fetch address 10. jr r31 returns to 5.
- setx 9; bex 20 -> r30=9, PC=20. With r30=0, bex falls through. Assert reset mid-EXEC -> no write, PC=0.
